// File: rtl/pc_mar_unit.sv
// Program counter and memory address register for the control unit.
// Jump targets arrive low byte first; the low byte is staged and only reaches PC with the high byte.
module pc_mar_unit #(
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] ORIGIN     = 16'h0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_origin,
   input  logic                  pc_enable,
   input  logic                  load_pc_low_byte,
   input  logic                  load_pc_high_byte,
   input  logic                  load_mar_pc,
   input  logic                  load_mar_addr_low,
   input  logic                  load_mar_addr_high,
   input  logic [DATA_WIDTH-1:0] bus_in,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic [ADDR_WIDTH-1:0] mar_out,
   output logic                  jump_staged,
   output logic                  err_collision
);

   typedef enum logic {IDLE, LOW_STAGED} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] staged_byte;
   logic [DATA_WIDTH-1:0] commit_low;
   logic                  pc_err;
   logic                  mar_err;

   always_comb begin
      pc_err  = 1'b0;
      mar_err = 1'b0;
      // A same-cycle low strobe supplies the low byte itself; otherwise a commit
      // from IDLE reuses PC[7:0] and is flagged.
      if (load_pc_low_byte)
         commit_low = bus_in;
      else if (state == LOW_STAGED)
         commit_low = staged_byte;
      else
         commit_low = pc_out[DATA_WIDTH-1:0];
      if (load_origin)
         pc_err = load_pc_high_byte | pc_enable | load_pc_low_byte;
      else if (load_pc_high_byte)
         pc_err = pc_enable | load_pc_low_byte | (state != LOW_STAGED);
      if (load_mar_pc)
         mar_err = load_mar_addr_low | load_mar_addr_high;
      else
         mar_err = load_mar_addr_low & load_mar_addr_high;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         staged_byte   <= '0;
         pc_out        <= '0;
         mar_out       <= '0;
         jump_staged   <= 1'b0;
         err_collision <= 1'b0;
      end else begin
         err_collision <= pc_err | mar_err;

         if (load_origin) begin
            pc_out      <= ORIGIN;
            state       <= IDLE;
            staged_byte <= '0;
            jump_staged <= 1'b0;
         end else if (load_pc_high_byte) begin
            pc_out      <= {bus_in, commit_low};
            state       <= IDLE;
            staged_byte <= '0;
            jump_staged <= 1'b0;
         end else begin
            if (pc_enable)
               pc_out <= pc_out + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            if (load_pc_low_byte) begin
               state       <= LOW_STAGED;
               staged_byte <= bus_in;
               jump_staged <= 1'b1;
            end else if (load_mar_pc && state == LOW_STAGED) begin
               // Fetch after a suppressed jump: drop the target, PC untouched.
               state       <= IDLE;
               staged_byte <= '0;
               jump_staged <= 1'b0;
            end
         end

         // MAR samples the pre-increment PC register.
         if (load_mar_pc) begin
            mar_out <= pc_out;
         end else begin
            if (load_mar_addr_low)
               mar_out[DATA_WIDTH-1:0] <= bus_in;
            if (load_mar_addr_high)
               mar_out[ADDR_WIDTH-1:DATA_WIDTH] <= bus_in;
         end
      end
   end

endmodule

// File: tb/tb_pc_mar_unit.sv
// Directed bench for pc_mar_unit: a vector table plus hand-written reset sequences.
module tb_pc_mar_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load_origin = 1'b0, pc_enable = 1'b0, load_pc_low_byte = 1'b0;
   logic        load_pc_high_byte = 1'b0, load_mar_pc = 1'b0;
   logic        load_mar_addr_low = 1'b0, load_mar_addr_high = 1'b0;
   logic [7:0]  bus_in = 8'h00;
   logic [15:0] pc_out, mar_out;
   logic        jump_staged, err_collision;

   int errors = 0;
   int checks = 0;

   localparam logic [6:0] S_NO = 7'b0000000;
   localparam logic [6:0] S_OR = 7'b1000000;
   localparam logic [6:0] S_EN = 7'b0100000;
   localparam logic [6:0] S_LO = 7'b0010000;
   localparam logic [6:0] S_HI = 7'b0001000;
   localparam logic [6:0] S_MP = 7'b0000100;
   localparam logic [6:0] S_ML = 7'b0000010;
   localparam logic [6:0] S_MH = 7'b0000001;

   typedef struct packed {
      logic [6:0]  s;
      logic [7:0]  bus;
      logic [15:0] pc;
      logic [15:0] mar;
      logic        js;
      logic        err;
   } vec_t;

   localparam int NV = 28;
   vec_t tbl [NV];

   pc_mar_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .ORIGIN(16'hF000)) dut (
      .clk(clk), .reset(reset),
      .load_origin(load_origin), .pc_enable(pc_enable),
      .load_pc_low_byte(load_pc_low_byte), .load_pc_high_byte(load_pc_high_byte),
      .load_mar_pc(load_mar_pc), .load_mar_addr_low(load_mar_addr_low),
      .load_mar_addr_high(load_mar_addr_high), .bus_in(bus_in),
      .pc_out(pc_out), .mar_out(mar_out),
      .jump_staged(jump_staged), .err_collision(err_collision)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [15:0] pc, input logic [15:0] mar,
                            input logic js, input logic err);
      check({tag, " pc"}, pc_out, pc);
      check({tag, " mar"}, mar_out, mar);
      check({tag, " js"}, {15'd0, jump_staged}, {15'd0, js});
      check({tag, " err"}, {15'd0, err_collision}, {15'd0, err});
   endtask

   // Drive strobes at the falling edge, let one rising edge pass, return at the next falling edge.
   task automatic step(input logic [6:0] s, input logic [7:0] b);
      {load_origin, pc_enable, load_pc_low_byte, load_pc_high_byte,
       load_mar_pc, load_mar_addr_low, load_mar_addr_high} = s;
      bus_in = b;
      @(posedge clk);
      @(negedge clk);
      {load_origin, pc_enable, load_pc_low_byte, load_pc_high_byte,
       load_mar_pc, load_mar_addr_low, load_mar_addr_high} = S_NO;
      bus_in = 8'h00;
   endtask

   initial begin
      tbl[0]  = '{S_NO,      8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0};
      tbl[1]  = '{S_OR,      8'h00, 16'hF000, 16'h0000, 1'b0, 1'b0};
      tbl[2]  = '{S_EN,      8'h00, 16'hF001, 16'h0000, 1'b0, 1'b0};
      tbl[3]  = '{S_EN,      8'h00, 16'hF002, 16'h0000, 1'b0, 1'b0};
      tbl[4]  = '{S_EN,      8'h00, 16'hF003, 16'h0000, 1'b0, 1'b0};
      tbl[5]  = '{S_LO,      8'hFF, 16'hF003, 16'h0000, 1'b1, 1'b0};
      tbl[6]  = '{S_HI,      8'hFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
      tbl[7]  = '{S_EN,      8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0};
      tbl[8]  = '{S_LO,      8'h34, 16'h0000, 16'h0000, 1'b1, 1'b0};
      tbl[9]  = '{S_HI,      8'h12, 16'h1234, 16'h0000, 1'b0, 1'b0};
      tbl[10] = '{S_LO,      8'h40, 16'h1234, 16'h0000, 1'b1, 1'b0};
      tbl[11] = '{S_HI,      8'h00, 16'h0040, 16'h0000, 1'b0, 1'b0};
      tbl[12] = '{S_LO,      8'h34, 16'h0040, 16'h0000, 1'b1, 1'b0};
      tbl[13] = '{S_MP,      8'h00, 16'h0040, 16'h0040, 1'b0, 1'b0};
      tbl[14] = '{S_HI,      8'h12, 16'h1240, 16'h0040, 1'b0, 1'b1};
      tbl[15] = '{S_NO,      8'h00, 16'h1240, 16'h0040, 1'b0, 1'b0};
      tbl[16] = '{S_ML,      8'hCD, 16'h1240, 16'h00CD, 1'b0, 1'b0};
      tbl[17] = '{S_MH,      8'hAB, 16'h1240, 16'hABCD, 1'b0, 1'b0};
      tbl[18] = '{S_MP|S_ML, 8'h77, 16'h1240, 16'h1240, 1'b0, 1'b1};
      tbl[19] = '{S_NO,      8'h00, 16'h1240, 16'h1240, 1'b0, 1'b0};
      tbl[20] = '{S_ML|S_MH, 8'h5A, 16'h1240, 16'h5A5A, 1'b0, 1'b1};
      tbl[21] = '{S_EN|S_HI, 8'h99, 16'h9940, 16'h5A5A, 1'b0, 1'b1};
      tbl[22] = '{S_OR|S_EN, 8'h00, 16'hF000, 16'h5A5A, 1'b0, 1'b1};
      tbl[23] = '{S_LO|S_HI, 8'h3C, 16'h3C3C, 16'h5A5A, 1'b0, 1'b1};
      tbl[24] = '{S_LO,      8'h11, 16'h3C3C, 16'h5A5A, 1'b1, 1'b0};
      tbl[25] = '{S_LO,      8'h22, 16'h3C3C, 16'h5A5A, 1'b1, 1'b0};
      tbl[26] = '{S_HI,      8'h33, 16'h3322, 16'h5A5A, 1'b0, 1'b0};
      tbl[27] = '{S_EN|S_MP, 8'h00, 16'h3323, 16'h3322, 1'b0, 1'b0};

      // Reset held low across edges, then released.
      repeat (3) @(negedge clk);
      check_all("reset held", 16'h0000, 16'h0000, 1'b0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      check_all("reset released", 16'h0000, 16'h0000, 1'b0, 1'b0);

      for (int i = 0; i < NV; i++) begin
         step(tbl[i].s, tbl[i].bus);
         check_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].mar, tbl[i].js, tbl[i].err);
      end

      // Async reset mid-jump with a pending error pulse, asserted between edges.
      step(S_LO|S_HI, 8'h77);
      step(S_LO, 8'h77);
      check_all("pre-reset staged", 16'h7777, 16'h3322, 1'b1, 1'b0);
      step(S_LO|S_ML|S_MH, 8'h66);
      check_all("pre-reset err", 16'h7777, 16'h6666, 1'b1, 1'b1);
      #2 reset = 1'b0;
      #1 check_all("async reset", 16'h0000, 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      step(S_HI, 8'h55);
      check_all("high after reset", 16'h5500, 16'h0000, 1'b0, 1'b1);
      step(S_NO, 8'h00);
      check_all("err pulse ends", 16'h5500, 16'h0000, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
